// File: rtl/ds_pkg.sv
// ds_pkg: shared types and constants for the direct-sequence spreader.
//   state_t           : spreader FSM state {IDLE, SPREAD}
//   DS_CHIPS_PER_BIT  : chips per data bit (one full 2^5-1 PN period)
//   DS_CNT_W          : chip counter width
package ds_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      SPREAD = 1'b1
   } state_t;

   localparam int DS_CHIPS_PER_BIT = 31;
   localparam int DS_CNT_W         = 5;

endpackage

// File: rtl/ds_bit_buffer.sv
// ds_bit_buffer: single-entry data bit buffer in front of the spreader.
// Ports:
//   clk_1m     in  chip clock
//   rst        in  synchronous active-high reset (empties the buffer)
//   data_in    in  bit offered by the source
//   data_valid in  data_in valid
//   unload     in  spreader takes the buffered bit this cycle
//   data_ready out buffer empty; bit accepted on data_valid & data_ready
//   full       out buffer holds a bit
//   bit_out    out buffered bit
module ds_bit_buffer (
   input  logic clk_1m,
   input  logic rst,
   input  logic data_in,
   input  logic data_valid,
   input  logic unload,
   output logic data_ready,
   output logic full,
   output logic bit_out
);

   logic load;

   assign data_ready = ~full;
   assign load       = data_valid & data_ready;

   always_ff @(posedge clk_1m) begin
      if (rst) begin
         full    <= 1'b0;
         bit_out <= 1'b0;
      end else begin
         if (load)
            bit_out <= data_in;
         // Unload first, then load: a same-cycle pair leaves the buffer full.
         full <= (full & ~unload) | load;
      end
   end

endmodule

// File: rtl/ds_spreader.sv
// ds_spreader: XORs each buffered data bit with CHIPS_PER_BIT consecutive
// PN chips. Bits are launched only on a PN-period boundary (chip_cnt wrap).
// Optional macro DS_DIFF_ENC_EN: differentially encode each bit at unload.
// Ports:
//   clk_1m     in  chip clock, rising edge
//   rst        in  synchronous active-high reset
//   pn_chip    in  PN chip, one per cycle
//   data_in    in  data bit to spread
//   data_valid in  data_in valid
//   data_ready out buffer empty (bit accepted on valid & ready)
//   chip_out   out spread chip (registered)
//   chip_valid out chip_out carries a spread chip
//   bit_start  out strobe on the first chip of each bit
//   underrun   out sticky: buffer empty at a bit boundary while spreading
module ds_spreader
   import ds_pkg::*;
#(
   parameter int CHIPS_PER_BIT = DS_CHIPS_PER_BIT,
   parameter int CNT_W         = DS_CNT_W
) (
   input  logic clk_1m,
   input  logic rst,
   input  logic pn_chip,
   input  logic data_in,
   input  logic data_valid,
   output logic data_ready,
   output logic chip_out,
   output logic chip_valid,
   output logic bit_start,
   output logic underrun
);

   state_t           state, next_state;
   logic [CNT_W-1:0] chip_cnt;
   logic             last_chip;
   logic             buf_full, buf_bit, unload;
   logic             active, enc_bit;

   assign last_chip = (chip_cnt == CNT_W'(CHIPS_PER_BIT - 1));

   ds_bit_buffer u_buf (
      .clk_1m     (clk_1m),
      .rst        (rst),
      .data_in    (data_in),
      .data_valid (data_valid),
      .unload     (unload),
      .data_ready (data_ready),
      .full       (buf_full),
      .bit_out    (buf_bit)
   );

`ifdef DS_DIFF_ENC_EN
   logic prev_enc;
   assign enc_bit = buf_bit ^ prev_enc;

   // Encoder history survives IDLE gaps; only reset clears it.
   always_ff @(posedge clk_1m) begin
      if (rst)
         prev_enc <= 1'b0;
      else if (unload)
         prev_enc <= enc_bit;
   end
`else
   assign enc_bit = buf_bit;
`endif

   always_ff @(posedge clk_1m) begin
      if (rst)
         state <= IDLE;
      else
         state <= next_state;
   end

   // Bits are taken only on the last chip of a period so that the first chip
   // lands on the epoch (chip_cnt==0) of the next period.
   always_comb begin
      next_state = state;
      unload     = 1'b0;
      case (state)
         IDLE: begin
            if (last_chip && buf_full) begin
               unload     = 1'b1;
               next_state = SPREAD;
            end
         end
         SPREAD: begin
            if (last_chip) begin
               if (buf_full)
                  unload = 1'b1;
               else
                  next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk_1m) begin
      if (rst) begin
         chip_cnt   <= '0;
         active     <= 1'b0;
         chip_out   <= 1'b0;
         chip_valid <= 1'b0;
         bit_start  <= 1'b0;
         underrun   <= 1'b0;
      end else begin
         chip_cnt <= last_chip ? '0 : chip_cnt + CNT_W'(1);
         if (unload)
            active <= enc_bit;
         if (state == SPREAD) begin
            chip_out   <= active ^ pn_chip;
            chip_valid <= 1'b1;
            bit_start  <= (chip_cnt == '0);
            if (last_chip && !buf_full)
               underrun <= 1'b1;
         end else begin
            chip_out   <= 1'b0;
            chip_valid <= 1'b0;
            bit_start  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ds_spreader.sv
// tb_ds_spreader: randomized self-checking bench for ds_spreader.
// The reference model schedules each accepted bit on the timeline: a bit
// accepted at cycle a is launched at the first period-end after a and is
// expected on chip_out for the following CHIPS_PER_BIT cycles.
module tb_ds_spreader;

   localparam int N    = 31;
   localparam int MAXC = 4096;

   logic clk_1m = 1'b0;
   logic rst = 1'b1;
   logic pn_chip = 1'b0;
   logic data_in = 1'b0;
   logic data_valid = 1'b0;
   logic data_ready, chip_out, chip_valid, bit_start, underrun;

   always #5 clk_1m = ~clk_1m;

   ds_spreader dut (
      .clk_1m     (clk_1m),
      .rst        (rst),
      .pn_chip    (pn_chip),
      .data_in    (data_in),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .chip_out   (chip_out),
      .chip_valid (chip_valid),
      .bit_start  (bit_start),
      .underrun   (underrun)
   );

   int checks = 0;
   int failures = 0;

   // Timeline model, indexed by cycle since reset release.
   // Output arrays describe the value seen after posedge c.
   bit m_valid [MAXC];
   bit m_chip  [MAXC];
   bit m_bs    [MAXC];
   bit m_unload[MAXC];
   bit m_busy  [MAXC];   // buffer full when posedge c samples data_valid
   bit m_pn    [MAXC];
   bit m_under;
   bit m_prev;
   int k;
   int n_acc;

   bit src_q[$];
   int gap_pct;
   int start_at;
   bit drop_valid;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, k, got, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < MAXC; i++) begin
         m_valid[i] = 0; m_chip[i] = 0; m_bs[i] = 0;
         m_unload[i] = 0; m_busy[i] = 0; m_pn[i] = 0;
      end
      m_under = 0;
      m_prev  = 0;
      k       = 0;
      n_acc   = 0;
      drop_valid = 0;
      src_q.delete();
   endtask

   task automatic accept(input bit b, input int a);
      bit enc;
      int u;
`ifdef DS_DIFF_ENC_EN
      enc = b ^ m_prev;
      m_prev = enc;
`else
      enc = b;
`endif
      // first period-end strictly after the accept cycle
      u = a + 1 + ((N - 1) - ((a + 1) % N));
      n_acc++;
      if (u + N < MAXC) begin
         for (int c = a + 1; c <= u; c++) m_busy[c] = 1;
         m_unload[u] = 1;
         for (int c = u + 1; c <= u + N; c++) begin
            m_valid[c] = 1;
            m_chip[c]  = enc;
            m_bs[c]    = (c == u + 1);
         end
      end
   endtask

   // Entered and left at a negedge.
   task automatic run_cycle();
      if (k > 0) begin
         int c;
         c = k - 1;
         if (m_valid[c] && (c % N) == N - 1 && !m_unload[c]) m_under = 1;
         chk("chip_valid", chip_valid, m_valid[c]);
         chk("bit_start", bit_start, m_bs[c]);
         chk("underrun", underrun, m_under);
         if (m_valid[c]) chk("chip_out", chip_out, m_chip[c] ^ m_pn[c]);
      end
      chk("data_ready", data_ready, !m_busy[k]);
      if (drop_valid) begin
         data_valid = 0;
         drop_valid = 0;
      end
      pn_chip = 1'($urandom);
      m_pn[k] = pn_chip;
      if (!data_valid) begin
         data_in = 1'($urandom);
         if (src_q.size() > 0 && k >= start_at && $urandom_range(99) >= gap_pct) begin
            data_valid = 1;
            data_in    = src_q[0];
         end
      end
      if (data_valid && !m_busy[k]) begin
         accept(src_q.pop_front(), k);
         drop_valid = 1;
      end
      @(posedge clk_1m);
      k++;
      @(negedge clk_1m);
   endtask

   task automatic do_reset(input int ncyc);
      rst = 1;
      data_valid = 0;
      data_in = 0;
      pn_chip = 0;
      repeat (ncyc) @(posedge clk_1m);
      @(negedge clk_1m);
      chk("rst_chip_out", chip_out, 0);
      chk("rst_chip_valid", chip_valid, 0);
      chk("rst_bit_start", bit_start, 0);
      chk("rst_underrun", underrun, 0);
      chk("rst_data_ready", data_ready, 1);
      rst = 0;
      model_clear();
   endtask

   task automatic run_seg(input int ncyc);
      for (int i = 0; i < ncyc; i++) run_cycle();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog cyc=%0d got=timeout exp=finish", k);
      $fatal(1, "watchdog");
   end

   initial begin
      model_clear();
      @(negedge clk_1m);
      do_reset(3);

      // single bit offered mid-period
      src_q.push_back(1); gap_pct = 0; start_at = 5;
      run_seg(100);
      chk("single_acc", n_acc, 1);

      // continuous 1,0,1 with back-pressure on bits 2 and 3
      do_reset(1);
      src_q.push_back(1); src_q.push_back(0); src_q.push_back(1);
      gap_pct = 0; start_at = 0;
      run_seg(130);
      chk("stream_acc", n_acc, 3);

      // 1,1,0 (encoded 1,0,0 with differential encoding)
      do_reset(1);
      src_q.push_back(1); src_q.push_back(1); src_q.push_back(0);
      gap_pct = 0; start_at = 0;
      run_seg(130);
      chk("enc_acc", n_acc, 3);

      // random bits with random gaps
      do_reset(1);
      for (int i = 0; i < 24; i++) src_q.push_back(1'($urandom));
      gap_pct = 85; start_at = 0;
      run_seg(1000);

      // reset in the middle of a bit (chip 15 of first bit)
      do_reset(1);
      src_q.push_back(1); src_q.push_back(0);
      gap_pct = 0; start_at = 0;
      run_seg(47);
      chk("mid_valid_before", chip_valid, 1);
      rst = 1;
      data_valid = 0;
      @(posedge clk_1m);
      @(negedge clk_1m);
      chk("mid_chip_valid", chip_valid, 0);
      chk("mid_underrun", underrun, 0);
      chk("mid_bit_start", bit_start, 0);
      chk("mid_data_ready", data_ready, 1);
      rst = 0;
      model_clear();

      // recovery after the abandoned bit
      src_q.push_back(0); src_q.push_back(1);
      gap_pct = 50; start_at = 3;
      run_seg(140);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
